// File: rtl/pcie_lane_pkg.sv
// Definitions shared by the PCIe lane 2x1 multiplexer and the 1x2 de-interleaver.
// Both sides agree on the lane byte width and on the de-interleaver state encoding.
package pcie_lane_pkg;

    localparam int LANE_WIDTH = 8;

    typedef enum logic {
        ST_EXPECT0 = 1'b0,
        ST_HAVE0   = 1'b1
    } laneState_t;

endpackage

// File: rtl/gap_timer.sv
// Counts consecutive idle cycles while a lane-0 byte is held.
// Expires on the MAX_GAP-th idle cycle, then restarts from zero.
module gap_timer #(
    parameter int MAX_GAP = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int CW = (MAX_GAP > 0) ? $clog2(MAX_GAP + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_GAP - 1);

    logic [CW-1:0] r_count;

    assign expire = (r_count == LAST) && inc;

    // The counter resets on expiry, so it never goes past LAST and never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear || expire) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/demux_1x2_8bits.sv
// Splits the serialized byte stream back into two lanes and aligns each pair.
// A lone lane-0 byte is flushed when the gap timer expires.
module demux_1x2_8bits
    import pcie_lane_pkg::*;
#(
    parameter int WIDTH   = LANE_WIDTH,
    parameter int MAX_GAP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic             valid0,
    output logic             valid1
);

    laneState_t       r_state;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_out0;
    logic [WIDTH-1:0] r_out1;
    logic             r_valid0;
    logic             r_valid1;

    laneState_t       w_stateNext;
    logic [WIDTH-1:0] w_holdNext;
    logic [WIDTH-1:0] w_out0Next;
    logic [WIDTH-1:0] w_out1Next;
    logic             w_valid0Next;
    logic             w_valid1Next;
    logic             w_gapInc;
    logic             w_gapClear;
    logic             w_gapExpire;

    // Any accepted byte restarts the idle count, whether it starts or completes a pair.
    assign w_gapClear = valid_in;

    gap_timer #(
        .MAX_GAP (MAX_GAP)
    ) u_gapTimer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_gapClear),
        .inc    (w_gapInc),
        .expire (w_gapExpire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_EXPECT0;
            r_hold   <= '0;
            r_out0   <= '0;
            r_out1   <= '0;
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_hold   <= w_holdNext;
            r_out0   <= w_out0Next;
            r_out1   <= w_out1Next;
            r_valid0 <= w_valid0Next;
            r_valid1 <= w_valid1Next;
        end
    end

    // A valid byte in HAVE0 always forms a pair, so it takes priority over a flush.
    always_comb begin
        w_stateNext  = r_state;
        w_holdNext   = r_hold;
        w_out0Next   = r_out0;
        w_out1Next   = r_out1;
        w_valid0Next = 1'b0;
        w_valid1Next = 1'b0;
        w_gapInc     = 1'b0;
        case (r_state)
            ST_EXPECT0: begin
                if (valid_in) begin
                    w_holdNext  = data_in;
                    w_stateNext = ST_HAVE0;
                end
            end
            ST_HAVE0: begin
                if (valid_in) begin
                    w_out0Next   = r_hold;
                    w_out1Next   = data_in;
                    w_valid0Next = 1'b1;
                    w_valid1Next = 1'b1;
                    w_stateNext  = ST_EXPECT0;
                end else begin
                    w_gapInc = 1'b1;
                    if (w_gapExpire) begin
                        w_out0Next   = r_hold;
                        w_valid0Next = 1'b1;
                        w_stateNext  = ST_EXPECT0;
                    end
                end
            end
        endcase
    end

    assign out0   = r_out0;
    assign out1   = r_out1;
    assign valid0 = r_valid0;
    assign valid1 = r_valid1;

endmodule

// File: tb/tb_demux_1x2_8bits.sv
// Self-checking bench for demux_1x2_8bits (MAX_GAP=4): a vector table plus hand-written
// corner sequences, with expected outputs queued at drive time and checked after each edge.
module tb_demux_1x2_8bits;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic [7:0] out0;
    logic [7:0] out1;
    logic       valid0;
    logic       valid1;

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic       ev0;
        logic       ev1;
        logic [7:0] eo0;
        logic [7:0] eo1;
        string      name;
    } vec_t;

    vec_t vecs[$];
    vec_t expQ[$];
    int   compared;
    int   mismatched;

    demux_1x2_8bits #(
        .WIDTH   (8),
        .MAX_GAP (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .out0     (out0),
        .out1     (out1),
        .valid0   (valid0),
        .valid1   (valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic v, input logic [7:0] d,
                                input logic ev0, input logic ev1,
                                input logic [7:0] eo0, input logic [7:0] eo1,
                                input string name);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d;
        r.ev0 = ev0; r.ev1 = ev1; r.eo0 = eo0; r.eo1 = eo1;
        r.name = name;
        return r;
    endfunction

    // Pops the expectation queued for this edge and compares all four outputs at once.
    task automatic checkOutput();
        vec_t e;
        compared++;
        if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_empty: got v0=%b v1=%b o0=%h o1=%h, expected a queued entry",
                     valid0, valid1, out0, out1);
        end else begin
            e = expQ.pop_front();
            if ({valid0, valid1, out0, out1} !== {e.ev0, e.ev1, e.eo0, e.eo1}) begin
                mismatched++;
                $display("[TB] FAIL %s: got v0=%b v1=%b o0=%h o1=%h, expected v0=%b v1=%b o0=%h o1=%h",
                         e.name, valid0, valid1, out0, out1, e.ev0, e.ev1, e.eo0, e.eo1);
            end
        end
    endtask

    task automatic applyStimulus(input vec_t vv);
        @(negedge clk);
        reset    = vv.rst;
        valid_in = vv.v;
        data_in  = vv.d;
        expQ.push_back(vv);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        valid_in   = 1'b0;
        data_in    = 8'h00;

        // Reset, back-to-back pairs, output hold
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, "reset_state"));
        vecs.push_back(mk(1, 1, 8'hFF, 0, 0, 8'h00, 8'h00, "reset_ignores_byte"));
        vecs.push_back(mk(0, 1, 8'h11, 0, 0, 8'h00, 8'h00, "b2b_first_held"));
        vecs.push_back(mk(0, 1, 8'h22, 1, 1, 8'h11, 8'h22, "b2b_pair1"));
        vecs.push_back(mk(0, 1, 8'h33, 0, 0, 8'h11, 8'h22, "b2b_third_held"));
        vecs.push_back(mk(0, 1, 8'h44, 1, 1, 8'h33, 8'h44, "b2b_pair2"));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h33, 8'h44, "hold_idle1"));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h33, 8'h44, "hold_idle2"));
        // Gapped pair: three idle cycles do not flush
        vecs.push_back(mk(0, 1, 8'hA5, 0, 0, 8'h33, 8'h44, "gap_lane0"));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h33, 8'h44, "gap_idle1"));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h33, 8'h44, "gap_idle2"));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h33, 8'h44, "gap_idle3"));
        vecs.push_back(mk(0, 1, 8'h5A, 1, 1, 8'hA5, 8'h5A, "gap_pair"));
        // Flush after four idle cycles; lane parity restarts afterwards
        vecs.push_back(mk(0, 1, 8'hC3, 0, 0, 8'hA5, 8'h5A, "flush_lane0"));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'hA5, 8'h5A, "flush_idle1"));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'hA5, 8'h5A, "flush_idle2"));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'hA5, 8'h5A, "flush_idle3"));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'hC3, 8'h5A, "flush_emit"));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'hC3, 8'h5A, "flush_after"));
        vecs.push_back(mk(0, 1, 8'h7E, 0, 0, 8'hC3, 8'h5A, "post_flush_lane0"));
        vecs.push_back(mk(0, 1, 8'h81, 1, 1, 8'h7E, 8'h81, "post_flush_pair"));
        // Valid byte on the would-be expiry cycle forms a pair
        vecs.push_back(mk(0, 1, 8'h01, 0, 0, 8'h7E, 8'h81, "collide_lane0"));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h7E, 8'h81, "collide_idle1"));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h7E, 8'h81, "collide_idle2"));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h7E, 8'h81, "collide_idle3"));
        vecs.push_back(mk(0, 1, 8'h02, 1, 1, 8'h01, 8'h02, "collide_pair"));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 8'h02, "collide_no_flush1"));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 8'h02, "collide_no_flush2"));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset mid-pair: the held 0xEE is discarded and never emitted
        applyStimulus(mk(0, 1, 8'hEE, 0, 0, 8'h01, 8'h02, "midpair_lane0"));
        applyStimulus(mk(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, "midpair_reset"));
        applyStimulus(mk(0, 1, 8'h10, 0, 0, 8'h00, 8'h00, "midpair_new_lane0"));
        applyStimulus(mk(0, 1, 8'h20, 1, 1, 8'h10, 8'h20, "midpair_new_pair"));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mk(0, 0, 8'h00, 0, 0, 8'h10, 8'h20, "midpair_no_stale_flush"));
        end

        // Reset while the gap timer is one step from expiry: no flush afterwards
        applyStimulus(mk(0, 1, 8'hD4, 0, 0, 8'h10, 8'h20, "gapreset_lane0"));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(0, 0, 8'h00, 0, 0, 8'h10, 8'h20, "gapreset_idle"));
        end
        applyStimulus(mk(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, "gapreset_reset"));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, "gapreset_quiet"));
        end

        // Sustained stream: one pair every two cycles
        begin
            logic [7:0] prevByte;
            logic [7:0] lastO0;
            logic [7:0] lastO1;
            logic [7:0] b;
            prevByte = 8'h00;
            lastO0   = 8'h00;
            lastO1   = 8'h00;
            for (int i = 0; i < 16; i++) begin
                b = 8'(8'h30 + 8'(i * 7));
                if (i % 2 == 0) begin
                    applyStimulus(mk(0, 1, b, 0, 0, lastO0, lastO1, "stream_lane0"));
                    prevByte = b;
                end else begin
                    applyStimulus(mk(0, 1, b, 1, 1, prevByte, b, "stream_pair"));
                    lastO0 = prevByte;
                    lastO1 = b;
                end
            end
            applyStimulus(mk(0, 0, 8'h00, 0, 0, lastO0, lastO1, "stream_hold"));
        end

        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, expected 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
